trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
- Synthesisable, parametrised successor to the processor test fixture's passive observation of commit signals.
- Records per-cycle commit records from the CPU core: pc_now, inst, RegWrite, write_reg, write_data.
- Storage is a DEPTH-entry on-chip trace buffer with PC-match trigger, stop-on-full or circular (wrap) mode, and a valid/ready readout port for a debug host or bench.
- Sits beside the processor top, tapping the same signals the fixture monitors.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- DATA_W, 32, width of pc, inst and write_data.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse: clear buffer, enter ARMED.
- stop  in  1  one-cycle pulse: end capture (wrap mode).
- wrap  in  1  0 = stop when full; 1 = circular overwrite. Sampled at arm.
- regwr_only  in  1  1 = store only cycles with RegWrite=1. Sampled at arm.
- trig_en  in  1  1 = wait for PC match; 0 = trigger immediately. Sampled at arm.
- trig_pc  in  DATA_W  trigger PC value.
- pc_now  in  DATA_W  committed PC.
- inst  in  DATA_W  committed instruction.
- RegWrite  in  1  register-write strobe.
- write_reg  in  REG_W  destination register.
- write_data  in  DATA_W  writeback data.
- rd_ready  in  1  host accepts the head entry.
- rd_valid  out  1  head entry available.
- rd_pc  out  DATA_W  head entry PC field.
- rd_inst  out  DATA_W  head entry instruction field.
- rd_wreg  out  REG_W  head entry destination register field.
- rd_wdata  out  DATA_W  head entry writeback data field.
- rd_regwrite  out  1  head entry RegWrite field.
- count  out  ADDR_W+1  entries held, 0..DEPTH.
- overflow  out  1  at least one entry overwritten in wrap mode.
- triggered  out  1  trigger fired since last arm.
- state_o  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.

Behaviour:
- Reset: state IDLE; wr_ptr = rd_ptr = 0; count = 0; overflow = 0; triggered = 0; latched mode bits = 0; rd_valid = 0.
- Reset mid-capture aborts immediately; buffer contents are don't-care.
- Qualifying sample: any cycle when regwr_only=0; only cycles with RegWrite=1 when regwr_only=1.
- arm (any state): pointers, count, overflow and triggered cleared; mode bits latched; next state ARMED.
- arm takes priority over stop and rd_ready in the same cycle.
- IDLE: inputs ignored except arm.
- ARMED: trigger condition is trig_en=0 or pc_now==trig_pc.
  - On trigger: triggered set; the trigger cycle itself is written if it qualifies; next state CAPTURE.
- CAPTURE: each qualifying cycle writes the record at wr_ptr; wr_ptr increments modulo DEPTH; count increments.
  - wrap=0: the write that makes count==DEPTH is the last; next state DONE.
  - wrap=1, count==DEPTH: the write overwrites the oldest entry; rd_ptr advances with wr_ptr; count stays DEPTH; overflow set.
  - stop (either mode): next state DONE.
  - A qualifying sample in the same cycle as stop is still written.
  - stop in ARMED goes to DONE with count=0.
- Write latency: a record sampled at edge N is visible in count and readable after edge N.
- Read port: show-ahead. rd_* fields reflect the entry at rd_ptr combinationally.
  - rd_valid = (state==DONE) and (count!=0). rd_valid is 0 in all other states.
  - rd_valid and rd_ready: rd_ptr increments modulo DEPTH; count decrements.
  - count reaching 0 leaves the state DONE; only arm exits DONE.
- Read order is oldest to newest. After a wrap, the oldest entry is the one at the post-overflow rd_ptr.
- Pointer wrap-around is modulo DEPTH. count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter, cleared by rst and by arm, is stored in every entry.
  - Extra output rd_ts [15:0] carries the head entry's timestamp.
  - The counter wraps silently from 65535 to 0.
- Undefined: no counter, no timestamp storage, no rd_ts port.
- All other behaviour is identical either way.

Test Plan:
- Reset mid-CAPTURE after 5 entries -> next edge state_o=00, count=0, rd_valid=0, overflow=0, triggered=0.
- arm with trig_en=0, wrap=0, regwr_only=0, DEPTH=16, PC stepping 0,4,8,... -> DONE after 16 writes.
  - count=16; read-out PCs 0x00..0x3C in order; count ends 0; rd_valid=0.
- trig_en=1, trig_pc=0x20, PC stepping from 0 -> triggered rises at PC 0x20; first entry read has rd_pc=0x20.
- wrap=1, 20 qualifying cycles at PC 0..0x4C, then stop -> overflow=1, count=16; reads return PCs 0x10..0x4C.
- regwr_only=1, stimulus alternating RegWrite 1/0 over 8 cycles, then stop -> count=4; all entries rd_regwrite=1 with the matching write_reg/write_data.
- arm and stop asserted in the same cycle during CAPTURE -> state_o=01, count=0.
  - With TRACE_TIMESTAMP_EN: rd_ts of the first entry after re-trigger equals cycles elapsed since that arm.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: triggered commit-trace capture buffer with wrap mode and show-ahead readout.
// Optional per-entry 16-bit timestamp enabled by defining TRACE_TIMESTAMP_EN.
module trace_capture_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              stop,
    input  logic              wrap,
    input  logic              regwr_only,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [DATA_W-1:0] pc_now,
    input  logic [DATA_W-1:0] inst,
    input  logic              RegWrite,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_inst,
    output logic [REG_W-1:0]  rd_wreg,
    output logic [DATA_W-1:0] rd_wdata,
    output logic              rd_regwrite,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              triggered,
`ifdef TRACE_TIMESTAMP_EN
    output logic [15:0]       rd_ts,
`endif
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              m_wrap, m_regwr, m_trig;
    logic              qual, hit, we, full, last, rd_fire, done_go;

    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] inst_mem  [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];
    logic [REG_W-1:0]  wreg_mem  [DEPTH];
    logic              rw_mem    [DEPTH];

    assign qual     = !m_regwr || RegWrite;
    assign hit      = !m_trig || (pc_now == trig_pc);
    assign full     = count == (ADDR_W+1)'(DEPTH);
    assign we       = !arm && qual && ((state == ARMED && hit) || state == CAPTURE);
    // In stop-on-full mode the write that fills the buffer ends the capture.
    assign last     = we && !m_wrap && count == (ADDR_W+1)'(DEPTH - 1);
    assign done_go  = (state == ARMED || state == CAPTURE) && (stop || last);
    assign rd_valid = state == DONE && count != '0;
    assign rd_fire  = rd_valid && rd_ready && !arm;
    assign state_o  = state;

    always_comb begin
        state_nx = state;
        state_nx = arm ? ARMED : done_go ? DONE : (state == ARMED && hit) ? CAPTURE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            m_wrap    <= 1'b0;
            m_regwr   <= 1'b0;
            m_trig    <= 1'b0;
        end else begin
            state <= state_nx;
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                triggered <= 1'b0;
                m_wrap    <= wrap;
                m_regwr   <= regwr_only;
                m_trig    <= trig_en;
            end else begin
                if (state == ARMED && hit) triggered <= 1'b1;
                if (we) wr_ptr <= wr_ptr + 1'b1;
                // A write into a full wrap buffer drops the oldest entry.
                if ((we && full) || rd_fire) rd_ptr <= rd_ptr + 1'b1;
                if (we && full) overflow <= 1'b1;
                if (we && !full) count <= count + 1'b1;
                else if (rd_fire) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem[wr_ptr]    <= pc_now;
            inst_mem[wr_ptr]  <= inst;
            wdata_mem[wr_ptr] <= write_data;
            wreg_mem[wr_ptr]  <= write_reg;
            rw_mem[wr_ptr]    <= RegWrite;
        end
    end

    assign rd_pc       = pc_mem[rd_ptr];
    assign rd_inst     = inst_mem[rd_ptr];
    assign rd_wdata    = wdata_mem[rd_ptr];
    assign rd_wreg     = wreg_mem[rd_ptr];
    assign rd_regwrite = rw_mem[rd_ptr];

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else ts <= arm ? 16'd0 : ts + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (we) ts_mem[wr_ptr] <= ts;
    end

    assign rd_ts = ts_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: directed table and sequence checks for trace_capture_buffer.
module tb_trace_capture_buffer;
    logic        clk = 1'b0;
    logic        rst, arm, stop, wrap, regwr_only, trig_en, RegWrite, rd_ready;
    logic [31:0] trig_pc, pc_now, inst, write_data;
    logic [4:0]  write_reg;
    logic        rd_valid, rd_regwrite, overflow, triggered;
    logic [31:0] rd_pc, rd_inst, rd_wdata;
    logic [4:0]  rd_wreg, count;
    logic [1:0]  state_o;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        arm, stop, rdy;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        v, tr;
        logic [31:0] rpc;
    } vec_t;
    vec_t tbl[11];

    trace_capture_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .wrap(wrap), .regwr_only(regwr_only),
        .trig_en(trig_en), .trig_pc(trig_pc), .pc_now(pc_now), .inst(inst), .RegWrite(RegWrite),
        .write_reg(write_reg), .write_data(write_data), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_wreg(rd_wreg), .rd_wdata(rd_wdata),
        .rd_regwrite(rd_regwrite), .count(count), .overflow(overflow), .triggered(triggered),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic status(input string tag, input logic [1:0] st, input logic [4:0] cnt,
                          input logic v, input logic tr, input logic ov);
        chk({tag, " state"}, 32'(state_o), 32'(st));
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(v));
        chk({tag, " triggered"}, 32'(triggered), 32'(tr));
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic rw, input logic [4:0] wr,
                         input logic [31:0] wd);
        pc_now = pc;
        inst = pc ^ 32'hA5A5_0000;
        RegWrite = rw;
        write_reg = wr;
        write_data = wd;
    endtask

    task automatic do_arm(input logic w, input logic r, input logic t, input logic [31:0] tp);
        arm = 1'b1;
        wrap = w;
        regwr_only = r;
        trig_en = t;
        trig_pc = tp;
        step;
        arm = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'b01, 5'd0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h10, 2'b01, 5'd0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 2'b01, 5'd0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h20, 2'b10, 5'd1, 1'b0, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h24, 2'b10, 5'd2, 1'b0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h28, 2'b11, 5'd3, 1'b1, 1'b1, 32'h20};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h2C, 2'b11, 5'd2, 1'b1, 1'b1, 32'h24};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h30, 2'b11, 5'd2, 1'b1, 1'b1, 32'h24};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h34, 2'b11, 5'd1, 1'b1, 1'b1, 32'h28};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h38, 2'b11, 5'd0, 1'b0, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h3C, 2'b11, 5'd0, 1'b0, 1'b1, 32'h0};

        rst = 1'b1; arm = 1'b0; stop = 1'b0; wrap = 1'b0; regwr_only = 1'b0; trig_en = 1'b0;
        trig_pc = '0; rd_ready = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 32'h0);
        step; step;
        rst = 1'b0;
        status("reset", 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        step;
        status("idle", 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

        // Trigger on PC 0x20, stop, then show-ahead readout and no count underflow.
        wrap = 1'b0; regwr_only = 1'b0; trig_en = 1'b1; trig_pc = 32'h20;
        for (int i = 0; i < 11; i++) begin
            arm = tbl[i].arm;
            stop = tbl[i].stop;
            rd_ready = tbl[i].rdy;
            drive(tbl[i].pc, 1'b1, 5'd1, 32'h0);
            step;
            status($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].v, tbl[i].tr, 1'b0);
            if (tbl[i].v) chk($sformatf("vec%0d rd_pc", i), rd_pc, tbl[i].rpc);
        end
        arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;

        // Stop-on-full: 16 writes, extra cycle ignored, ordered readout.
        do_arm(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            drive(32'(4 * i), 1'b0, 5'd0, 32'h0);
            step;
        end
        status("full", 2'b11, 5'd16, 1'b1, 1'b1, 1'b0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full rd_pc%0d", i), rd_pc, 32'(4 * i));
            chk($sformatf("full rd_inst%0d", i), rd_inst, 32'(4 * i) ^ 32'hA5A5_0000);
            step;
        end
        rd_ready = 1'b0;
        status("full drained", 2'b11, 5'd0, 1'b0, 1'b1, 1'b0);

        // Wrap mode: 20 writes with stop on the last; oldest four are lost.
        do_arm(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive(32'(4 * i), 1'b0, 5'd0, 32'h0);
            stop = (i == 19);
            step;
        end
        stop = 1'b0;
        status("wrap", 2'b11, 5'd16, 1'b1, 1'b1, 1'b1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wrap rd_pc%0d", i), rd_pc, 32'h10 + 32'(4 * i));
            step;
        end
        rd_ready = 1'b0;
        chk("wrap drained count", 32'(count), 32'd0);

        // RegWrite-only filtering.
        do_arm(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            drive(32'(4 * i), (i % 2) == 0, 5'(i + 1), 32'h100 + 32'(i));
            step;
        end
        stop = 1'b1;
        drive(32'h20, 1'b0, 5'd0, 32'h0);
        step;
        stop = 1'b0;
        status("regwr", 2'b11, 5'd4, 1'b1, 1'b1, 1'b0);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("regwr rw%0d", k), 32'(rd_regwrite), 32'd1);
            chk($sformatf("regwr wreg%0d", k), 32'(rd_wreg), 32'(2 * k + 1));
            chk($sformatf("regwr wdata%0d", k), rd_wdata, 32'h100 + 32'(2 * k));
            step;
        end
        rd_ready = 1'b0;

        // arm + stop together in CAPTURE: arm wins, then re-trigger at PC 0x80.
        do_arm(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(32'(4 * i), 1'b0, 5'd0, 32'h0);
            step;
        end
        status("pre arm+stop", 2'b10, 5'd3, 1'b0, 1'b1, 1'b0);
        arm = 1'b1; stop = 1'b1; trig_en = 1'b1; trig_pc = 32'h80;
        step;
        arm = 1'b0; stop = 1'b0;
        status("arm+stop", 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 5'd0, 32'h0); step;
        drive(32'h4, 1'b0, 5'd0, 32'h0); step;
        drive(32'h80, 1'b0, 5'd0, 32'h0); step;
        stop = 1'b1;
        drive(32'h84, 1'b0, 5'd0, 32'h0); step;
        stop = 1'b0;
        status("retrigger", 2'b11, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("retrigger rd_pc", rd_pc, 32'h80);
`ifdef TRACE_TIMESTAMP_EN
        chk("retrigger rd_ts", 32'(rd_ts), 32'd2);
`endif

        // Asynchronous reset during a wrapped capture.
        do_arm(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            drive(32'(4 * i), 1'b0, 5'd0, 32'h0);
            step;
        end
        status("pre reset", 2'b10, 5'd16, 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        step;
        status("mid reset", 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step;
        status("post reset", 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
